// File: rtl/rej_uniform_sampler_if.sv
// Byte-stream / coefficient bus between keccak, rej_uniform_sampler and the
// matrix-A polynomial RAM writer. The optional o_rej_cnt signal exists only
// when REJ_CNT_EN is defined.
interface rej_uniform_sampler_if #(
   parameter int unsigned BW_COEF = 12
);
   logic               i_start;
   logic [63:0]        i_bytes;
   logic               i_bytes_valid;
   logic               o_bytes_ready;
   logic [BW_COEF-1:0] o_coef;
   logic               o_coef_valid;
   logic [7:0]         o_coef_idx;
   logic               o_busy;
   logic               o_done;
`ifdef REJ_CNT_EN
   logic [9:0]         o_rej_cnt;
`endif

   // upstream / consumer side
   modport master (
      output i_start, i_bytes, i_bytes_valid,
      input  o_bytes_ready, o_coef, o_coef_valid, o_coef_idx, o_busy, o_done
`ifdef REJ_CNT_EN
      , input o_rej_cnt
`endif
   );

   // sampler side
   modport slave (
      input  i_start, i_bytes, i_bytes_valid,
      output o_bytes_ready, o_coef, o_coef_valid, o_coef_idx, o_busy, o_done
`ifdef REJ_CNT_EN
      , output o_rej_cnt
`endif
   );
endinterface

// File: rtl/rej_uniform_sampler.sv
// Kyber Parse / SampleNTT rejection sampler. Consumes 64-bit SHAKE128 words,
// splits every 3 bytes into two 12-bit candidates, and emits the ones below Q
// with a running index until N_COEF coefficients have been produced.
// Optional feature: define REJ_CNT_EN to add the saturating o_rej_cnt output.
module rej_uniform_sampler #(
   parameter int unsigned Q       = 3329,
   parameter int unsigned N_COEF  = 256,
   parameter int unsigned BW_COEF = 12
) (
   input logic                  i_clk,
   input logic                  i_rstn,
   rej_uniform_sampler_if.slave smp
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [BW_COEF-1:0] Q_W      = BW_COEF'(Q);
   localparam logic [8:0]         LAST_IDX = 9'(N_COEF - 1);

   state_t             state_q, state_n;
   logic [7:0]         buf_q [16];
   logic [7:0]         buf_n [16];
   logic [4:0]         fill_q, fill_n, fill_pop;
   logic               phase_q, phase_n;
   logic [8:0]         count_q, count_n;
   logic [BW_COEF-1:0] coef_q, coef_n, cand;
   logic               coef_valid_q, coef_valid_n;
   logic [7:0]         idx_q, idx_n;
   logic               done_q;
   logic               ready, eval, accept, last, push, pop;
   logic [7:0][7:0]    word_b;
   logic [3:0]         slot;

   // word_b[7] is the first stream byte
   assign word_b = smp.i_bytes;

   // phase 0 looks at d1 (b0 + low nibble of b1), phase 1 at d2
   assign cand   = phase_q ? BW_COEF'({buf_q[2], buf_q[1][7:4]})
                           : BW_COEF'({buf_q[1][3:0], buf_q[0]});
   assign ready  = (state_q == RUN) && (fill_q <= 5'd8);
   assign eval   = (state_q == RUN) && !smp.i_start && (phase_q || (fill_q >= 5'd3));
   assign accept = eval && (cand < Q_W);
   assign last   = accept && (count_q == LAST_IDX);
   assign push   = smp.i_bytes_valid && ready && !smp.i_start;
   assign pop    = eval && phase_q;

   // next-state, buffer shift/append and output staging
   always_comb begin
      state_n      = state_q;
      buf_n        = buf_q;
      fill_pop     = fill_q;
      fill_n       = fill_q;
      phase_n      = phase_q;
      count_n      = count_q;
      coef_n       = coef_q;
      coef_valid_n = 1'b0;
      idx_n        = idx_q;
      slot         = '0;

      // pop first so a simultaneous push lands behind the surviving bytes
      if (pop) begin
         fill_pop = fill_q - 5'd3;
         for (int unsigned i = 0; i < 13; i++) begin
            buf_n[4'(i)] = buf_q[4'(i + 3)];
         end
      end
      if (push) begin
         for (int unsigned k = 0; k < 8; k++) begin
            slot        = fill_pop[3:0] + 4'(k);
            buf_n[slot] = word_b[3'(7 - k)];
         end
      end
      fill_n = fill_pop + (push ? 5'd8 : 5'd0);

      if (eval) begin
         phase_n = ~phase_q;
      end
      if (accept) begin
         count_n      = count_q + 9'd1;
         coef_n       = cand;
         coef_valid_n = 1'b1;
         idx_n        = count_q[7:0];
      end

      unique case (state_q)
         IDLE: state_n = IDLE;
         RUN: begin
            // a final d1 discards its pending d2 and any leftover bytes
            if (last) begin
               state_n = DONE;
               fill_n  = '0;
               phase_n = 1'b0;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      if (smp.i_start) begin
         state_n = RUN;
         fill_n  = '0;
         phase_n = 1'b0;
         count_n = '0;
      end
   end

   // state and datapath registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q      <= IDLE;
         buf_q        <= '{default: '0};
         fill_q       <= '0;
         phase_q      <= 1'b0;
         count_q      <= '0;
         coef_q       <= '0;
         coef_valid_q <= 1'b0;
         idx_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_n;
         buf_q        <= buf_n;
         fill_q       <= fill_n;
         phase_q      <= phase_n;
         count_q      <= count_n;
         coef_q       <= coef_n;
         coef_valid_q <= coef_valid_n;
         idx_q        <= idx_n;
         done_q       <= (state_q == DONE);
      end
   end

   assign smp.o_bytes_ready = ready;
   assign smp.o_coef        = coef_q;
   assign smp.o_coef_valid  = coef_valid_q;
   assign smp.o_coef_idx    = idx_q;
   assign smp.o_busy        = (state_q == RUN);
   assign smp.o_done        = done_q;

`ifdef REJ_CNT_EN
   logic [9:0] rej_q;

   // saturating count of rejected candidates for the current polynomial
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rej_q <= '0;
      end else if (smp.i_start) begin
         rej_q <= '0;
      end else if (eval && !accept && (rej_q != '1)) begin
         rej_q <= rej_q + 10'd1;
      end
   end

   assign smp.o_rej_cnt = rej_q;
`endif

endmodule
